branch_unit: RTL

// - Jump-resolution stage directly upstream of the program counter. Decodes the 9-bit fetched

---
 rtl/branch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// Jump-resolution stage: decodes branch instructions against registered ALU flags and a
// loadable jump-target LUT, drives Jen/Jump to the PC. Optional call stack via CALL_STACK_EN.
module branch_unit #(
  parameter int LUT_DEPTH   = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [8:0] Instruction,
  input  logic [7:0] PC,
  input  logic       zero_in,
  input  logic       lt_in,
  input  logic       flag_we,
  input  logic       done_in,
  input  logic       lut_we,
  input  logic [3:0] lut_addr,
  input  logic [7:0] lut_data,
  output logic       Jen,
  output logic [7:0] Jump,
  output logic       busy,
  output logic [7:0] taken_cnt,
  output logic       stk_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic       z_q;
  logic       lt_q;
  logic [7:0] lut [LUT_DEPTH];

  logic       active;
  logic       is_br;
  logic       cond_ok;
  logic [7:0] target;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign active = (state == RUN) && !done_in;
  assign is_br  = (Instruction[8:6] == 3'b111);
  assign target = lut[Instruction[3:0]];

  always_comb begin
    cond_ok = 1'b0;
    case (Instruction[5:4])
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = z_q;
      2'b10: cond_ok = !z_q;
      2'b11: cond_ok = lt_q;
    endcase
  end

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [7:0]      stk [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic            is_call;
  logic            is_ret;
  logic            stk_full;
  logic            stk_empty;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  assign is_call   = (Instruction[8:6] == 3'b110) && !Instruction[5];
  assign is_ret    = (Instruction[8:6] == 3'b110) &&  Instruction[5];
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign push_idx  = IDX_W'(sp);
  assign top_idx   = IDX_W'(sp - SP_W'(1));

  always_comb begin
    Jen  = 1'b0;
    Jump = 8'h00;
    if (active) begin
      if ((is_br && cond_ok) || is_call) begin
        Jen  = 1'b1;
        Jump = target;
      end else if (is_ret && !stk_empty) begin
        Jen  = 1'b1;
        Jump = stk[top_idx];
      end
    end
  end

  // Stack pointer and error flag are control; return addresses are plain storage.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sp      <= '0;
      stk_err <= 1'b0;
    end else if (start) begin
      sp <= '0;
    end else if (active) begin
      if (is_call) begin
        if (stk_full) stk_err <= 1'b1;
        else          sp      <= sp + SP_W'(1);
      end else if (is_ret) begin
        if (stk_empty) stk_err <= 1'b1;
        else           sp      <= sp - SP_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!start && active && is_call && !stk_full)
      stk[push_idx] <= PC + 8'd1;
  end
`else
  logic unused_pc;

  assign unused_pc = ^PC;
  assign stk_err   = 1'b0;

  always_comb begin
    Jen  = 1'b0;
    Jump = 8'h00;
    if (active && is_br && cond_ok) begin
      Jen  = 1'b1;
      Jump = target;
    end
  end
`endif

  // Run-state FSM, flags, LUT and taken counter; branches always see pre-edge flags/LUT.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      taken_cnt <= 8'h00;
      z_q       <= 1'b0;
      lt_q      <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= 8'h00;
    end else begin
      if (start) begin
        state     <= RUN;
        busy      <= 1'b1;
        taken_cnt <= 8'h00;
      end else begin
        if (state == RUN && done_in) begin
          state <= DONE;
          busy  <= 1'b0;
        end
        if (Jen) taken_cnt <= sat_inc(taken_cnt);
      end
      if (flag_we) begin
        z_q  <= zero_in;
        lt_q <= lt_in;
      end
      if (lut_we) lut[lut_addr] <= lut_data;
    end
  end

endmodule
